// File: rtl/bpu_pkg.sv
// Shared branch-predictor definitions: 2-bit direction counter encoding and helpers.
package bpu_pkg;

  localparam int unsigned PC_W  = 31;
  localparam int unsigned CTR_W = 2;

  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CTR_SNT   = 2'b00;
  localparam ctr_t CTR_WNT   = 2'b01;
  localparam ctr_t CTR_WT    = 2'b10;
  localparam ctr_t CTR_ST    = 2'b11;
  localparam ctr_t CTR_ALLOC = CTR_WT;

  // Saturating step toward the resolved direction.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != CTR_ST) res = ctr_t'(ctr + CTR_W'(1));
    end else begin
      if (ctr != CTR_SNT) res = ctr_t'(ctr - CTR_W'(1));
    end
    return res;
  endfunction

  // Taken prediction is the counter MSB.
  function automatic logic ctr_pred(input ctr_t ctr);
    return ctr[CTR_W-1];
  endfunction

endpackage

// File: rtl/bpu_btb2.sv
// Direct-mapped BTB with per-entry 2-bit direction counter; 1-cycle registered lookup.
module bpu_btb2
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            btb_rd,
  input  logic [30:0]     pc_r,
  output logic            btb_hit,
  output logic [30:0]     target_pc_r,
  input  logic            btb_wr,
  input  logic [30:0]     pc_w,
  input  logic [31:0]     target_pc_w,
  input  logic            taken_w,
  input  logic            btb_invalid
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = PC_W - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [ENTRIES];
  ctr_t               r_ctr [ENTRIES];
  logic [PC_W-1:0]    r_tgt [ENTRIES];

  logic               r_btb_hit;
  logic [PC_W-1:0]    r_target_pc;

  logic [IDX_W-1:0]   w_ridx;
  logic [TAG_W-1:0]   w_rtag;
  logic               w_rhit;
  logic [IDX_W-1:0]   w_widx;
  logic [TAG_W-1:0]   w_wtag;
  logic               w_wmatch;
  logic               w_unused;

  // Split lookup and update PCs into index/tag and evaluate tag matches.
  always_comb begin
    w_ridx   = pc_r[IDX_W-1:0];
    w_rtag   = pc_r[PC_W-1:IDX_W];
    w_widx   = pc_w[IDX_W-1:0];
    w_wtag   = pc_w[PC_W-1:IDX_W];
    w_rhit   = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag) && ctr_pred(r_ctr[w_ridx]);
    w_wmatch = r_valid[w_widx] && (r_tag[w_widx] == w_wtag);
  end

  // Target bit 0 is never stored (halfword-aligned PCs).
  assign w_unused = target_pc_w[0];

  // Entry array: invalidate, train on resolution, or allocate on a taken miss.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        r_tag[i] <= '0;
        r_ctr[i] <= CTR_WNT;
        r_tgt[i] <= '0;
      end
    end else if (btb_invalid) begin
      r_valid <= '0;
    end else if (btb_wr) begin
      if (w_wmatch) begin
        r_ctr[w_widx] <= ctr_next(r_ctr[w_widx], taken_w);
        if (taken_w) r_tgt[w_widx] <= target_pc_w[31:1];
      end else if (taken_w) begin
        r_valid[w_widx] <= 1'b1;
        r_tag[w_widx]   <= w_wtag;
        r_ctr[w_widx]   <= CTR_ALLOC;
        r_tgt[w_widx]   <= target_pc_w[31:1];
      end
    end
  end

  // Lookup result registers; hold when no lookup, invalidation kills the hit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btb_hit   <= 1'b0;
      r_target_pc <= '0;
    end else begin
      if (btb_invalid)  r_btb_hit <= 1'b0;
      else if (btb_rd)  r_btb_hit <= w_rhit;
      if (btb_rd)       r_target_pc <= r_tgt[w_ridx];
    end
  end

  assign btb_hit     = r_btb_hit;
  assign target_pc_r = r_target_pc;

endmodule
